// File: rtl/pucch_math_pkg.sv
// Shared arithmetic definitions for the PUCCH index/cyclic-shift modulo blocks.
package pucch_math_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int unsigned DATA_W = 16;

    // Reciprocal constants used by the single-cycle multiply modulo (mod_comb):
    // ONE_DIV_x = floor(2**RECIP_SHIFT / x) + 1.
    localparam int unsigned RECIP_SHIFT = 24;
    localparam logic [31:0] ONE_DIV_12  = 32'((64'd1 << RECIP_SHIFT) / 64'd12  + 64'd1);
    localparam logic [31:0] ONE_DIV_24  = 32'((64'd1 << RECIP_SHIFT) / 64'd24  + 64'd1);
    localparam logic [31:0] ONE_DIV_30  = 32'((64'd1 << RECIP_SHIFT) / 64'd30  + 64'd1);
    localparam logic [31:0] ONE_DIV_192 = 32'((64'd1 << RECIP_SHIFT) / 64'd192 + 64'd1);

endpackage

// File: rtl/mod_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits.
module mod_div_step #(
    parameter int unsigned DW      = 16,
    parameter int unsigned DIVIDER = 12
) (
    input  logic [DW:0] i_rem,
    input  logic        i_bit,
    output logic [DW:0] o_rem,
    output logic        o_qbit
);

    // i_rem is always < DIVIDER, so its top bit is zero; the extra bit here
    // just keeps every operand width-consistent.
    logic [DW+1:0] w_shift;
    logic [DW+1:0] w_div;
    logic [DW+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_div   = (DW+2)'(DIVIDER);
    assign w_diff  = w_shift - w_div;

    // Compare and conditionally subtract.
    always_comb begin
        o_qbit = (w_shift >= w_div);
        o_rem  = o_qbit ? w_diff[DW:0] : w_shift[DW:0];
    end

endmodule

// File: rtl/mod_seq_div.sv
// Sequential restoring divider by a constant: one quotient bit per cycle,
// valid/ready on both sides.
module mod_seq_div
    import pucch_math_pkg::*;
#(
    parameter int unsigned DW      = DATA_W,
    parameter int unsigned DIVIDER = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_dividend,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_quotient,
    output logic [DW-1:0] o_remainder
);

    localparam int unsigned CW = $clog2(DW);

    if (DW < 2 || DW > 30) begin : g_bad_dw
        $error("mod_seq_div: DW out of supported range");
    end
    if (DIVIDER == 0 || 64'(DIVIDER) > ((64'd1 << DW) - 64'd1)) begin : g_bad_div
        $error("mod_seq_div: DIVIDER must be in 1 .. 2**DW-1");
    end

    div_state_t     r_state;
    div_state_t     w_next_state;
    logic [DW-1:0]  r_shift;
    logic [DW:0]    r_rem;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_quotient;
    logic [DW-1:0]  r_remainder;
    logic [DW:0]    w_step_rem;
    logic           w_qbit;
    logic [DW-1:0]  w_shift_next;

    mod_div_step #(
        .DW      (DW),
        .DIVIDER (DIVIDER)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_shift[DW-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_shift_next = {r_shift[DW-2:0], w_qbit};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next_state = CALC;
            CALC:    if (r_cnt == '0) w_next_state = DONE;
            DONE:    if (i_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: load, restoring steps, and result capture on the last step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_dividend;
                        r_rem   <= '0;
                        r_cnt   <= CW'(DW - 1);
                    end
                end
                CALC: begin
                    r_shift <= w_shift_next;
                    r_rem   <= w_step_rem;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quotient  <= w_shift_next;
                        r_remainder <= w_step_rem[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready     = (r_state == IDLE);
    assign o_valid     = (r_state == DONE);
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

endmodule

// File: doc/mod_seq_div.md
Name: mod_seq_div

Overview:
- Sequential restoring divider. Computes quotient and remainder of a DW-bit unsigned dividend by the constant DIVIDER, one bit per cycle.
- Sequential counterpart of mod_comb, which is the single-cycle reciprocal-multiply modulo.
- Used where a full 16-bit quotient is needed, and as an independent cross-check of mod_comb in PUCCH cyclic-shift / index arithmetic.
- Valid/ready handshake on both input and output.

Parameters:
- DW, 16, dividend / quotient / remainder width.
- DIVIDER, 12, constant divisor. Legal range 1 .. 2**DW-1; an elaboration-time $error is raised otherwise.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  dividend valid.
- o_ready  output  1  block can accept a dividend.
- i_dividend  input  DW  unsigned dividend.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_quotient  output  DW  floor(i_dividend / DIVIDER).
- o_remainder  output  DW  i_dividend mod DIVIDER.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - state=IDLE, o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, bit counter=0.
  - Reset has priority over every other event, including mid-CALC and DONE; any operation in progress is discarded.
- FSM states IDLE, CALC, DONE. o_ready=1 only in IDLE; o_valid=1 only in DONE; both are registered/state-decoded with no combinational path from inputs.
- IDLE:
  - On an edge with i_valid=1, latch i_dividend into a shift register, clear the partial remainder (DW+1 bits), set counter=DW-1, go to CALC.
  - i_valid=0 stays IDLE.
- CALC, one restoring step per edge, MSB first:
  - r' = {r[DW-1:0], dividend_msb}.
  - If r' >= DIVIDER: r = r' - DIVIDER and the quotient bit is 1; else r = r' and the quotient bit is 0.
  - The quotient bit is shifted into the low end of the dividend/quotient register.
  - The counter decrements. The step taken when counter=0 is the last one; on that edge go to DONE and load o_quotient / o_remainder.
- Latency:
  - Exactly DW CALC edges, so o_valid is first high in the cycle DW clocks after the accepting edge (16 for the default).
  - Throughput is 1 result per DW+2 cycles minimum: accept, DW steps, handshake.
- DONE:
  - o_valid=1; o_quotient and o_remainder are held stable while i_ready=0, for an unbounded time.
  - On an edge with i_ready=1, go to IDLE; o_valid drops and o_ready rises the next cycle.
  - Outputs keep their last values in IDLE/CALC; they are not cleared.
- i_valid and i_dividend are ignored outside IDLE. A change of i_dividend during CALC has no effect.
- Width rules:
  - The partial remainder is DW+1 bits so that the compare cannot overflow for DIVIDER up to 2**DW-1.
  - o_remainder is always < DIVIDER.
  - The quotient for DIVIDER=1 equals the dividend, with remainder 0.
- Boundaries:
  - Dividend 0 gives q=0, r=0.
  - Dividend 2**DW-1 needs no special case.
  - Dividend < DIVIDER gives q=0, r=dividend.

Decomposition:
- Shared package pucch_math_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - localparam DATA_W=16;
  - the ONE_DIV_DIVIDER constants for 12/24/30/192, so mod_comb and its benches use the same source.
- Sub-module mod_div_step is combinational and holds one restoring step:
  - inputs: partial remainder and next dividend bit;
  - outputs: new remainder and quotient bit.
  - It is instantiated once, inside the CALC datapath.

Test Plan:
- DIVIDER=192, dividend 65535 -> after exactly 16 cycles o_valid=1, q=341, r=63; o_ready=0 throughout CALC/DONE.
- DIVIDER=12, dividend 1000 with i_ready held 0 for 5 cycles after o_valid -> q=83, r=4, outputs stable all 5 cycles; o_ready=1 the cycle after the i_ready handshake.
- DIVIDER=12, back-to-back i_valid=1 with dividends 0, 11, 12 -> (0,0), (0,11), (1,0); each accepted only when o_ready=1; i_dividend changes during CALC ignored.
- DIVIDER=30, i_rst pulsed at CALC step 7 of dividend 5000 -> next cycle state IDLE, o_valid=0, o_ready=1, outputs 0; a following 5000 yields q=166, r=20.
- Exhaustive, DIVIDER in {12,24,30,192}, dividends 0..65535 -> o_remainder matches the existing mod_comb golden vector files and a mod_comb instance with the same DIVIDER. o_quotient*DIVIDER + o_remainder == dividend; the bench prints PASSED/FAILED.
- DIVIDER=1, dividend 40000 -> q=40000, r=0.
